// File: rtl/panel_input_conditioner_pkg.sv
// panel_pkg: shared widths and default debounce settings for the panel input conditioner
package panel_pkg;
    localparam int NUM_SW = 4;
    localparam int NUM_DP = 4;
    localparam int SEL_W = 3;
    localparam int DB_CYCLES_DEFAULT = 50000;
    localparam int CNT_W_DEFAULT = 16;
endpackage

// File: rtl/panel_input_conditioner_debounce_ch.sv
// debounce_ch: single-bit two-flop synchronizer followed by a consecutive-difference debouncer
module debounce_ch #(
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);
    logic [1:0] sync;
    logic [CNT_W-1:0] cnt;
    // synchronize raw, then accept the new level only after DB_CYCLES consecutive differing clocks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            cnt <= '0;
            stable <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
                stable <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/panel_input_conditioner.sv
// panel_input_conditioner: debounces switches and buttons and steps the function-select code
module panel_input_conditioner
    import panel_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_SW-1:0] sw_raw,
    input  logic [NUM_DP-1:0] dp_raw,
    input  logic             step_raw,
    output logic [NUM_SW-1:0] sw,
    output logic [NUM_DP-1:0] dp,
    output logic [SEL_W-1:0]  s,
    output logic             step_pulse
);
    logic stable_step;
    logic step_prev;
    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_ch #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db (
            .clk(clk), .rst(rst), .raw(sw_raw[i]), .stable(sw[i])
        );
    end
    for (genvar i = 0; i < NUM_DP; i++) begin : g_dp
        debounce_ch #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db (
            .clk(clk), .rst(rst), .raw(dp_raw[i]), .stable(dp[i])
        );
    end
    debounce_ch #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_step (
        .clk(clk), .rst(rst), .raw(step_raw), .stable(stable_step)
    );
    // a debounced press (rise only) emits one pulse and advances s, wrapping modulo 8
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_prev <= 1'b0;
            step_pulse <= 1'b0;
            s <= '0;
        end else begin
            step_prev <= stable_step;
            step_pulse <= stable_step & ~step_prev;
            s <= (stable_step & ~step_prev) ? s + 1'b1 : s;
        end
    end
endmodule

// File: tb/tb_panel_input_conditioner.sv
// tb_panel_input_conditioner: scoreboard bench with a window-based debounce reference model
module tb_panel_input_conditioner;
    localparam int DB = 4;
    localparam int CW = 3;
    localparam int NCH = 9;

    typedef struct packed {
        logic [3:0] sw;
        logic [3:0] dp;
        logic [2:0] s;
        logic       p;
    } exp_t;

    logic       clk = 0;
    logic       rst = 1;
    logic [3:0] sw_raw = '1;
    logic [3:0] dp_raw = '1;
    logic       step_raw = 1;
    logic [3:0] sw;
    logic [3:0] dp;
    logic [2:0] s;
    logic       step_pulse;

    int tests = 0;
    int fails = 0;
    int pulses = 0;

    exp_t q[$];

    bit       hist[NCH][DB+2];
    bit       st[NCH];
    bit       prev_step;
    bit [2:0] s_m;

    panel_input_conditioner #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .sw_raw(sw_raw), .dp_raw(dp_raw), .step_raw(step_raw),
        .sw(sw), .dp(dp), .s(s), .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    // Reference: a channel flips once its DB most recent synchronized samples
    // (raw samples delayed two edges) all disagree with the current stable level.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                st[c] = 0;
                for (int j = 0; j < DB + 2; j++) hist[c][j] = 0;
            end
            prev_step = 0;
            s_m = 0;
            q.delete();
        end else begin
            logic [NCH-1:0] raw;
            bit pulse;
            exp_t e;
            raw = {step_raw, dp_raw, sw_raw};
            pulse = st[8] & ~prev_step;
            prev_step = st[8];
            if (pulse) s_m = s_m + 3'd1;
            for (int c = 0; c < NCH; c++) begin
                bit all_diff;
                for (int j = DB + 1; j > 0; j--) hist[c][j] = hist[c][j-1];
                hist[c][0] = raw[c];
                all_diff = 1;
                for (int j = 2; j < DB + 2; j++) if (hist[c][j] == st[c]) all_diff = 0;
                if (all_diff) st[c] = ~st[c];
            end
            e.sw = {st[3], st[2], st[1], st[0]};
            e.dp = {st[7], st[6], st[5], st[4]};
            e.s = s_m;
            e.p = pulse;
            q.push_back(e);
        end
    end

    // Monitor: outputs must be cleared under reset, otherwise match the queued expectation
    always @(negedge clk) begin
        if (rst) begin
            tests++;
            if ({sw, dp, s, step_pulse} !== '0) begin
                fails++;
                $display("FAIL reset_state: got sw=%b dp=%b s=%b p=%b, want all zero", sw, dp, s, step_pulse);
            end
        end else if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests++;
            if ({sw, dp, s, step_pulse} !== e) begin
                fails++;
                $display("FAIL scoreboard @%0t: got sw=%b dp=%b s=%b p=%b, want sw=%b dp=%b s=%b p=%b",
                         $time, sw, dp, s, step_pulse, e.sw, e.dp, e.s, e.p);
            end
            if (step_pulse === 1'b1) pulses++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        // reset held with all inputs high
        tick(9);
        sw_raw = '0;
        dp_raw = '0;
        step_raw = 0;
        tick(1);
        rst = 0;
        tick(10);
        // switch pattern change
        sw_raw = 4'b0101;
        tick(12);
        check("sw_0101", sw, 5);
        // glitch shorter than debounce window, then a held press
        dp_raw[2] = 1;
        tick(3);
        dp_raw[2] = 0;
        tick(10);
        check("dp_glitch", dp, 0);
        dp_raw[2] = 1;
        tick(10);
        check("dp_held", dp, 4);
        // eight step presses wrap s back to zero
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            step_raw = 1;
            tick(10);
            step_raw = 0;
            tick(10);
        end
        check("step_pulse_count", pulses, 8);
        check("s_wrap", s, 0);
        // reset in the middle of a switch debounce
        sw_raw = 4'b1111;
        tick(2);
        rst = 1;
        tick(2);
        rst = 0;
        tick(5);
        check("sw_before_latency", sw, 0);
        tick(5);
        check("sw_after_reset", sw, 15);
        // step held through reset release gives exactly one increment
        step_raw = 1;
        rst = 1;
        tick(2);
        rst = 0;
        pulses = 0;
        tick(20);
        check("held_step_pulses", pulses, 1);
        check("held_step_s", s, 1);
        // random traffic with occasional resets
        for (int k = 0; k < 1500; k++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(5) == 0) sw_raw[b] = ~sw_raw[b];
                if ($urandom_range(5) == 0) dp_raw[b] = ~dp_raw[b];
            end
            if ($urandom_range(7) == 0) step_raw = ~step_raw;
            rst = ($urandom_range(299) == 0);
            tick(1);
        end
        rst = 0;
        tick(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/panel_input_conditioner.md
Name: panel_input_conditioner

Overview:
Input-side companion to the lab-board LED function selector. It conditions the raw board inputs and produces the values the selector consumes:
- `sw[3:0]`: debounced slide-switch levels.
- `dp[3:0]`: debounced push-button levels.
- `s[2:0]`: function-select code, stepped by a dedicated push-button.

It sits between the FPGA pins and the selector logic. All outputs are registered and glitch-free.

Parameters:
- DB_CYCLES, 50000, number of consecutive clocks a synchronized input must differ from its stable value before the stable value updates (1 ms at 50 MHz); legal range 2..65535.
- CNT_W, 16, width of each debounce counter; must satisfy 2^CNT_W > DB_CYCLES.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- sw_raw  input  4  raw slide-switch pins, asynchronous to clk
- dp_raw  input  4  raw push-button pins, asynchronous to clk, 1 = pressed
- step_raw  input  1  raw "next function" push-button, 1 = pressed
- sw  output  4  debounced switch levels
- dp  output  4  debounced push-button levels
- s  output  3  function-select code
- step_pulse  output  1  one-clock pulse on each debounced press of step_raw

Behaviour:
- Reset is asynchronous, active-high, and clears all of the following while asserted, regardless of input state:
  - synchronizer flops, debounce counters and stable values;
  - outputs: `sw=0000`, `dp=0000`, `s=000`, `step_pulse=0`.
- Synchronizer, per channel (9 channels: 4 sw, 4 dp, 1 step): two flip-flops; `syn` is the second-stage output.
- Debounce, per channel, using `stable` (1 bit) and `cnt` (CNT_W bits):
  - If `syn == stable`: `cnt <= 0`.
  - Else if `cnt == DB_CYCLES-1`: `stable <= syn` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
- Debounce latency: a raw level held constant reaches `stable` on exactly the (DB_CYCLES+2)th rising edge, counting the first edge that samples the new raw level as edge 1.
- Glitch rejection: any raw excursion that returns before `stable` updates resets `cnt` to 0 and never changes `stable`.
- Outputs `sw` and `dp` are the stable values of their channels, driven directly from the stable flops with no extra stage.
- Step logic uses an edge detector: `step_prev <= stable_step`.
  - A rise is `stable_step & ~step_prev`.
  - On a rise: `step_pulse <= 1` and `s <= s+1` modulo 8 (111 wraps to 000). Both update on the same edge, one clock after `stable_step` rises.
  - Otherwise: `step_pulse <= 0` and `s` holds.
  - Release (the falling edge of `stable_step`) has no effect.
- Step button held through reset release: `stable_step` resets to 0, so if step_raw is still pressed, one rise occurs after debounce. This is required behaviour: one increment to `s=001`.
- Channels are fully independent. Simultaneous changes on several channels each debounce with their own counter, with no interaction.
- Reset mid-debounce discards the partial count. After release, latency restarts per the rule above, counted from the first edge after reset deassertion.
- No combinational path exists from any input to any output.

Decomposition:
- Shared package `panel_pkg` holds:
  - `NUM_SW = 4`, `NUM_DP = 4`, `SEL_W = 3`;
  - `DB_CYCLES_DEFAULT = 50000`, `CNT_W_DEFAULT = 16`.
- One sub-module, `debounce_ch`: a single-bit 2-FF synchronizer plus counter and stable flop, parameterized by DB_CYCLES/CNT_W. It is instantiated 9 times.
- The top level adds the step edge detector and the `s` counter.

Test Plan (DB_CYCLES=4, CNT_W=3):
1. Hold rst=1 with all raw inputs = 1 for 10 clocks → sw=0000, dp=0000, s=000, step_pulse=0 throughout.
2. After reset, change sw_raw 0000→0101 and hold → sw stays 0000 through edge 5 and becomes 0101 after edge 6; sw[3] and sw[1] never toggle.
3. Pulse dp_raw[2]=1 for 3 clocks, then 0 → dp stays 0000. Then hold dp_raw[2]=1 → dp=0100 after edge 6.
4. Press step_raw 8 times (each press held 10 clocks, released 10 clocks) → exactly 8 single-clock step_pulse assertions; s sequence is 001,010,…,111,000; s changes on the same edge as each pulse; no change on releases.
5. Set sw_raw=1111, then assert rst on the 3rd clock for 2 clocks and deassert, keeping sw_raw=1111 → sw=0000 during and after reset until the 6th edge after deassertion, then sw=1111.
6. Hold step_raw=1 across reset release → one step_pulse 7 edges after deassertion, s=001, then no further pulses while held.
